// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcodes, bus size codes, FSM encoding and op decode for the MEM-stage LSU.
// LSU_LWLR_EN adds the unaligned LWL/LWR/SWL/SWR ops to the load/store decode.
package mem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_DRAIN} state_t;

  function automatic logic is_load(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
`ifdef LSU_LWLR_EN
      EXE_LWL_OP, EXE_LWR_OP: is_load = 1'b1;
`endif
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
`ifdef LSU_LWLR_EN
      EXE_SWL_OP, EXE_SWR_OP: is_store = 1'b1;
`endif
      default: is_store = 1'b0;
    endcase
  endfunction

  // LWL/LWR/SWL/SWR never fault, so they fall to the default arm.
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = a[0];
      EXE_LW_OP, EXE_SW_OP:             misaligned = (a != 2'b00);
      default:                          misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane steering: store data/strobes out, load data extract+extend in.
// LSU_LWLR_EN enables the LWL/LWR merge and SWL/SWR partial-strobe paths.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int LB    = $clog2(LANES)
) (
  input  logic [7:0]        op,
  input  logic [LB-1:0]     lane,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rt_old,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [LANES-1:0]  wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [31:0]       rdata,
  output logic [1:0]        size
);

  logic [LB-1:0] wlane;
  logic [1:0]    b;
  logic [31:0]   word, w32;
  logic [3:0]    s4;
  logic [7:0]    bv;
  logic [15:0]   hv;

`ifndef LSU_LWLR_EN
  logic unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

  always_comb begin
    // wlane: first lane of the 32-bit word that holds the access
    wlane = lane & ~LB'(3);
    b     = lane[1:0];
    word  = bus_rdata[{wlane, 3'b000} +: 32];
    bv    = word[{b, 3'b000} +: 8];
    hv    = b[1] ? word[31:16] : word[15:0];
    rdata = word;
    w32   = wdata;
    s4    = 4'b0000;
    size  = SIZE_W;
    wstrb = '0;
    case (op)
      EXE_LB_OP:  begin rdata = {{24{bv[7]}}, bv};  size = SIZE_B; end
      EXE_LBU_OP: begin rdata = {24'd0, bv};        size = SIZE_B; end
      EXE_LH_OP:  begin rdata = {{16{hv[15]}}, hv}; size = SIZE_H; end
      EXE_LHU_OP: begin rdata = {16'd0, hv};        size = SIZE_H; end
      EXE_SB_OP: begin
        w32 = {4{wdata[7:0]}}; size = SIZE_B; wstrb = LANES'(1) << lane;
      end
      EXE_SH_OP: begin
        w32 = {2{wdata[15:0]}}; size = SIZE_H; wstrb = LANES'(3) << lane;
      end
      EXE_SW_OP: s4 = 4'b1111;
`ifdef LSU_LWLR_EN
      EXE_LWL_OP: rdata = (word << {~b, 3'b000}) | (rt_old & ~(32'hFFFF_FFFF << {~b, 3'b000}));
      EXE_LWR_OP: rdata = (word >> {b, 3'b000}) | (rt_old & ~(32'hFFFF_FFFF >> {b, 3'b000}));
      EXE_SWL_OP: begin w32 = wdata >> {~b, 3'b000}; s4 = 4'b1111 >> ~b; end
      EXE_SWR_OP: begin w32 = wdata << {b, 3'b000};  s4 = 4'b1111 << b;  end
`endif
      default: ;
    endcase
    if (s4 != 4'b0000) wstrb = LANES'(s4) << wlane;
    bus_wdata = {(LANES / 4){w32}};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: one SRAM-like bus transaction per instruction, stalls until done.
// LSU_LWLR_EN (via the package decode and mem_lane_align) adds LWL/LWR/SWL/SWR.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int LB    = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [7:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rt_old,
  input  logic              flush,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [LANES-1:0]  data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t            state, state_nxt;
  logic [7:0]        op_q, cur_op;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [31:0]       wdata_q, rt_old_q, cur_wdata, cur_rt_old, ld_data;
  logic              mis, start, use_q;

  assign mis      = misaligned(op, addr[1:0]);
  assign adel     = mem_valid & is_load(op) & mis;
  assign ades     = mem_valid & is_store(op) & mis;
  assign badvaddr = (adel | ades) ? addr : '0;
  assign start    = mem_valid & (is_load(op) | is_store(op)) & ~mis & ~flush;

  // Once the request is issued, the bus fields and load capture come from the latched copy.
  assign use_q      = (state == ST_REQ) || (state == ST_WAIT);
  assign cur_op     = use_q ? op_q     : op;
  assign cur_addr   = use_q ? addr_q   : addr;
  assign cur_wdata  = use_q ? wdata_q  : wdata;
  assign cur_rt_old = use_q ? rt_old_q : rt_old;

  assign data_wr   = is_store(cur_op);
  assign data_addr = {cur_addr[ADDR_W-1:LB], {LB{1'b0}}};

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .op        (cur_op),
    .lane      (cur_addr[LB-1:0]),
    .wdata     (cur_wdata),
    .rt_old    (cur_rt_old),
    .bus_rdata (data_rdata),
    .wstrb     (data_wstrb),
    .bus_wdata (data_wdata),
    .rdata     (ld_data),
    .size      (data_size)
  );

  always_comb begin
    state_nxt = state;
    data_req  = 1'b0;
    stall     = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        data_req  = 1'b1;
        stall     = 1'b1;
        state_nxt = data_addr_ok ? ST_WAIT : ST_REQ;
      end
      ST_REQ: begin
        stall = 1'b1;
        if (flush) state_nxt = ST_IDLE;
        else begin
          data_req = 1'b1;
          if (data_addr_ok) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        // A response arriving with the flush is simply dropped; nothing left to drain.
        if (data_data_ok) state_nxt = flush ? ST_IDLE : ST_DONE;
        else if (flush)   state_nxt = ST_DRAIN;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_DRAIN: begin
        stall = start;
        if (data_data_ok) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rt_old_q    <= '0;
    end else begin
      state       <= state_nxt;
      rdata_valid <= 1'b0;
      if (state == ST_IDLE && start) begin
        op_q     <= op;
        addr_q   <= addr;
        wdata_q  <= wdata;
        rt_old_q <= rt_old;
      end
      if (state == ST_WAIT && data_data_ok && !flush && is_load(op_q)) begin
        rdata_valid <= 1'b1;
        rdata       <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: directed loads/stores, expected bus requests and load results queued,
// checked by a negedge monitor; a 64-bit instance runs in lockstep for lane-half checks.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_valid = 1'b0, flush = 1'b0;
  logic [7:0]  op = 8'd0;
  logic [31:0] addr = '0, wdata = '0, rt_old = '0;
  logic        stall, rdata_valid, adel, ades, data_req, data_wr;
  logic [31:0] rdata, badvaddr, data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  logic        stall_64, rdata_valid_64, adel_64, ades_64, data_req_64, data_wr_64;
  logic [31:0] rdata_64, badvaddr_64, data_addr_64;
  logic [63:0] data_wdata_64;
  logic [1:0]  data_size_64;
  logic [7:0]  data_wstrb_64;

  int          ok_dly = 0, data_dly = 0;
  logic [31:0] mem_word = '0;
  int          checks = 0, errors = 0;

  typedef struct {
    bit        wr;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  strb;
    bit [7:0]  strb64;
  } req_t;
  req_t        reqq[$];
  logic [31:0] rdq[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .op(op), .addr(addr), .wdata(wdata),
    .rt_old(rt_old), .flush(flush), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .adel(adel), .ades(ades), .badvaddr(badvaddr), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata));

  mem_access_ctrl #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .op(op), .addr(addr), .wdata(wdata),
    .rt_old(rt_old), .flush(flush), .stall(stall_64), .rdata(rdata_64),
    .rdata_valid(rdata_valid_64), .adel(adel_64), .ades(ades_64), .badvaddr(badvaddr_64),
    .data_req(data_req_64), .data_wr(data_wr_64), .data_size(data_size_64),
    .data_addr(data_addr_64), .data_wdata(data_wdata_64), .data_wstrb(data_wstrb_64),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata({data_rdata, data_rdata}));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void exp_req(input bit wr, input bit [1:0] sz, input bit [31:0] a,
                                  input bit [31:0] wd, input bit [3:0] s, input bit [7:0] s64);
    req_t r;
    r.wr = wr; r.size = sz; r.addr = a; r.wdata = wd; r.strb = s; r.strb64 = s64;
    reqq.push_back(r);
  endfunction

  // Bus slave: addr_ok after ok_dly cycles of req, data_ok data_dly cycles after acceptance.
  initial begin : bus
    bit acc_q, pend;
    int wcnt, dcnt, dly_q;
    logic [31:0] word_q;
    acc_q = 0; pend = 0; wcnt = 0; dcnt = 0; dly_q = 0; word_q = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    forever begin
      @(posedge clk); #2;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (rst) begin
        pend = 0; wcnt = 0;
      end else begin
        if (acc_q) begin pend = 1; dcnt = 0; end
        if (pend) begin
          if (dcnt >= dly_q) begin
            data_data_ok = 1'b1; data_rdata = word_q; pend = 0;
          end else dcnt++;
        end else if (data_req) begin
          if (wcnt >= ok_dly) begin
            data_addr_ok = 1'b1; wcnt = 0; dly_q = data_dly; word_q = mem_word;
          end else wcnt++;
        end else wcnt = 0;
      end
      @(negedge clk);
      acc_q = data_req && data_addr_ok && !rst;
    end
  end

  always @(negedge clk) begin : mon
    req_t e;
    logic [31:0] er;
    if (!rst) begin
      if (data_req) begin
        if (reqq.size() == 0) chk("req_unexpected", 1'b1, 1'b0);
        else begin
          e = reqq[0];
          chk("req_wr", data_wr, e.wr);
          chk("req_size", data_size, e.size);
          chk("req_addr", data_addr, e.addr);
          chk("req_wstrb", data_wstrb, e.strb);
          chk("req_wstrb64", data_wstrb_64, e.strb64);
          if (e.wr) chk("req_wdata", data_wdata, e.wdata);
          if (data_addr_ok) void'(reqq.pop_front());
        end
      end
      if (rdata_valid) begin
        if (rdq.size() == 0) chk("rd_unexpected", 1'b1, 1'b0);
        else begin
          er = rdq.pop_front();
          chk("rdata", rdata, er);
          chk("rdata64", rdata_64, er);
          chk("rdata_valid64", rdata_valid_64, 1'b1);
        end
      end
    end
  end

  // Presents one instruction and holds it until stall drops; checks stalled-cycle count.
  task automatic issue(input logic [7:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rto, input int exp_stall);
    int n;
    n = 0;
    @(posedge clk); #1;
    mem_valid = 1'b1; op = o; addr = a; wdata = wd; rt_old = rto;
    @(negedge clk);
    while (stall && n < 50) begin n++; @(negedge clk); end
    chk("stall_cycles", n, exp_stall);
  endtask

  task automatic err_case(input logic [7:0] o, input logic [31:0] a, input bit e_adel,
                          input bit e_ades);
    @(posedge clk); #1;
    mem_valid = 1'b1; op = o; addr = a;
    @(negedge clk);
    chk("adel", adel, e_adel);
    chk("ades", ades, e_ades);
    chk("badvaddr", badvaddr, (e_adel | e_ades) ? a : 32'h0);
    chk("err_req", data_req, 1'b0);
    chk("err_stall", stall, 1'b0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", data_req, 1'b0);
    chk("rst_rvalid", rdata_valid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Loads, minimum latency
    mem_word = 32'h80FF_FFFF;
    exp_req(0, SIZE_B, 32'h1000, 0, 4'h0, 8'h00); rdq.push_back(32'hFFFF_FF80);
    issue(EXE_LB_OP, 32'h1003, 0, 0, 2);
    exp_req(0, SIZE_B, 32'h1000, 0, 4'h0, 8'h00); rdq.push_back(32'h0000_0080);
    issue(EXE_LBU_OP, 32'h1003, 0, 0, 2);
    mem_word = 32'h8001_1234;
    exp_req(0, SIZE_H, 32'h1000, 0, 4'h0, 8'h00); rdq.push_back(32'hFFFF_8001);
    issue(EXE_LH_OP, 32'h1002, 0, 0, 2);
    exp_req(0, SIZE_H, 32'h1000, 0, 4'h0, 8'h00); rdq.push_back(32'h0000_1234);
    issue(EXE_LHU_OP, 32'h1000, 0, 0, 2);
    mem_word = 32'hDEAD_BEEF;
    exp_req(0, SIZE_W, 32'h1004, 0, 4'h0, 8'h00); rdq.push_back(32'hDEAD_BEEF);
    issue(EXE_LW_OP, 32'h1004, 0, 0, 2);

    // Stores
    exp_req(1, SIZE_H, 32'h2000, 32'hABCD_ABCD, 4'b1100, 8'h0C);
    issue(EXE_SH_OP, 32'h2002, 32'h1234_ABCD, 0, 2);
    exp_req(1, SIZE_B, 32'h2000, 32'hA5A5_A5A5, 4'b0010, 8'h02);
    issue(EXE_SB_OP, 32'h2001, 32'h0000_00A5, 0, 2);
    exp_req(1, SIZE_W, 32'h2004, 32'hCAFE_F00D, 4'b1111, 8'hF0);
    issue(EXE_SW_OP, 32'h2004, 32'hCAFE_F00D, 0, 2);

    // Address errors
    err_case(EXE_LW_OP, 32'h3001, 1, 0);
    err_case(EXE_LH_OP, 32'h3003, 1, 0);
    err_case(EXE_SW_OP, 32'h3002, 0, 1);
    err_case(EXE_SH_OP, 32'h3001, 0, 1);

    // addr_ok delayed 3 cycles: request fields re-checked every cycle while pending
    ok_dly = 3; mem_word = 32'h0123_4567;
    exp_req(0, SIZE_W, 32'h4000, 0, 4'h0, 8'h00); rdq.push_back(32'h0123_4567);
    issue(EXE_LW_OP, 32'h4000, 0, 0, 5);
    ok_dly = 0;

    // Flush while waiting for data: old response drained, only the new load returns
    data_dly = 3; mem_word = 32'h5555_5555;
    exp_req(0, SIZE_W, 32'h5000, 0, 4'h0, 8'h00);
    @(posedge clk); #1;
    mem_valid = 1'b1; op = EXE_LW_OP; addr = 32'h5000;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; addr = 32'h6000; mem_word = 32'h6666_6666; data_dly = 0;
    exp_req(0, SIZE_W, 32'h6000, 0, 4'h0, 8'h00); rdq.push_back(32'h6666_6666);
    @(negedge clk);
    chk("drain_no_req", data_req, 1'b0);
    chk("drain_stall", stall, 1'b1);
    n = 0;
    while (stall && n < 50) begin n++; @(negedge clk); end
    chk("flush_stall_cycles", n, 5);

`ifdef LSU_LWLR_EN
    mem_word = 32'hAABB_CCDD;
    exp_req(0, SIZE_W, 32'h7000, 0, 4'h0, 8'h00); rdq.push_back(32'hCCDD_3344);
    issue(EXE_LWL_OP, 32'h7001, 0, 32'h1122_3344, 2);
    exp_req(0, SIZE_W, 32'h7000, 0, 4'h0, 8'h00); rdq.push_back(32'h1122_AABB);
    issue(EXE_LWR_OP, 32'h7002, 0, 32'h1122_3344, 2);
    exp_req(1, SIZE_W, 32'h7000, 32'h1234_5678, 4'b1111, 8'h0F);
    issue(EXE_SWL_OP, 32'h7003, 32'h1234_5678, 0, 2);
    exp_req(1, SIZE_W, 32'h7000, 32'h0000_0012, 4'b0001, 8'h01);
    issue(EXE_SWL_OP, 32'h7000, 32'h1234_5678, 0, 2);
`else
    err_case(EXE_LWL_OP, 32'h7001, 0, 0);
    err_case(EXE_SWR_OP, 32'h7002, 0, 0);
`endif

    @(posedge clk); #1 mem_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("reqq_empty", reqq.size(), 0);
    chk("rdq_empty", rdq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
